// File: rtl/match_extender.sv
// Extends an LZ match candidate by comparing WIDTH_BYTES bytes per cycle through two
// unaligned history read ports, then returns the exact match length over a valid/ready handshake.
module match_extender #(
    parameter int WIDTH_BYTES     = 8,
    parameter int SIZE_BYTES_LOG2 = 15,
    parameter int MAX_MATCH_LEN   = 64,
    localparam int LEN_BITS       = $clog2(MAX_MATCH_LEN + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [SIZE_BYTES_LOG2-1:0]   req_cur_addr,
    input  logic [SIZE_BYTES_LOG2-1:0]   req_cand_addr,
    input  logic [LEN_BITS-1:0]          req_limit,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [LEN_BITS-1:0]          resp_len,
    output logic                         cur_read_enable,
    output logic [SIZE_BYTES_LOG2-1:0]   cur_read_address,
    input  logic [WIDTH_BYTES*8-1:0]     cur_read_data,
    output logic                         cand_read_enable,
    output logic [SIZE_BYTES_LOG2-1:0]   cand_read_address,
    input  logic [WIDTH_BYTES*8-1:0]     cand_read_data
);

    localparam int OFF_W = LEN_BITS + 1;
    localparam int EQ_W  = $clog2(WIDTH_BYTES + 1);
    localparam logic [LEN_BITS-1:0] MAX_LEN_C = LEN_BITS'(MAX_MATCH_LEN);
    localparam logic [OFF_W-1:0]    STEP_C    = OFF_W'(WIDTH_BYTES);
    localparam logic [EQ_W-1:0]     FULL_C    = EQ_W'(WIDTH_BYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                       state_q, state_d;
    logic [SIZE_BYTES_LOG2-1:0]   cur_base_q, cur_base_d;
    logic [SIZE_BYTES_LOG2-1:0]   cand_base_q, cand_base_d;
    logic [LEN_BITS-1:0]          lim_q, lim_d;
    logic [OFF_W-1:0]             len_q, len_d;
    logic [OFF_W-1:0]             issue_off_q, issue_off_d;
    logic [LEN_BITS-1:0]          resp_len_q, resp_len_d;
    logic                         resp_valid_q, resp_valid_d;

    logic                         rd_en_s;
    logic [SIZE_BYTES_LOG2-1:0]   cur_addr_s;
    logic [SIZE_BYTES_LOG2-1:0]   cand_addr_s;
    logic [EQ_W-1:0]              eq_s;
    logic [OFF_W-1:0]             nl_s;
    logic [LEN_BITS-1:0]          lim_in_s;

    // Number of equal bytes counted from byte 0 up to the first difference.
    function automatic logic [EQ_W-1:0] lead_eq(input logic [WIDTH_BYTES*8-1:0] a,
                                                 input logic [WIDTH_BYTES*8-1:0] b);
        logic [EQ_W-1:0] cnt;
        logic            hit;
        cnt = '0;
        hit = 1'b0;
        for (int i = 0; i < WIDTH_BYTES; i++) begin
            if (!hit && (a[i*8 +: 8] == b[i*8 +: 8])) begin
                cnt = cnt + EQ_W'(1);
            end else begin
                hit = 1'b1;
            end
        end
        return cnt;
    endfunction

    assign req_ready         = (state_q == IDLE);
    assign resp_valid        = resp_valid_q;
    assign resp_len          = resp_len_q;
    assign cur_read_enable   = rd_en_s;
    assign cand_read_enable  = rd_en_s;
    assign cur_read_address  = cur_addr_s;
    assign cand_read_address = cand_addr_s;

    // Next-state, speculative read issue and length accumulation.
    always_comb begin
        state_d      = state_q;
        cur_base_d   = cur_base_q;
        cand_base_d  = cand_base_q;
        lim_d        = lim_q;
        len_d        = len_q;
        issue_off_d  = issue_off_q;
        resp_len_d   = resp_len_q;
        resp_valid_d = resp_valid_q;
        rd_en_s      = 1'b0;
        cur_addr_s   = cur_base_q + SIZE_BYTES_LOG2'(issue_off_q);
        cand_addr_s  = cand_base_q + SIZE_BYTES_LOG2'(issue_off_q);
        eq_s         = lead_eq(cur_read_data, cand_read_data);
        nl_s         = len_q + OFF_W'(eq_s);
        lim_in_s     = (req_limit > MAX_LEN_C) ? MAX_LEN_C : req_limit;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    cur_base_d  = req_cur_addr;
                    cand_base_d = req_cand_addr;
                    lim_d       = lim_in_s;
                    len_d       = '0;
                    issue_off_d = STEP_C;
                    if (lim_in_s == '0) begin
                        resp_len_d   = '0;
                        resp_valid_d = 1'b1;
                        state_d      = DONE;
                    end else begin
                        rd_en_s     = 1'b1;
                        cur_addr_s  = req_cur_addr;
                        cand_addr_s = req_cand_addr;
                        state_d     = RUN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // The read issued on the terminating cycle is simply never consumed.
                rd_en_s     = 1'b1;
                issue_off_d = issue_off_q + STEP_C;
                if ((eq_s < FULL_C) || (nl_s >= {1'b0, lim_q})) begin
                    resp_len_d   = (nl_s < {1'b0, lim_q}) ? nl_s[LEN_BITS-1:0] : lim_q;
                    resp_valid_d = 1'b1;
                    state_d      = DONE;
                end else begin
                    len_d = nl_s;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                resp_valid_d = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cur_base_q   <= '0;
            cand_base_q  <= '0;
            lim_q        <= '0;
            len_q        <= '0;
            issue_off_q  <= '0;
            resp_len_q   <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_base_q   <= cur_base_d;
            cand_base_q  <= cand_base_d;
            lim_q        <= lim_d;
            len_q        <= len_d;
            issue_off_q  <= issue_off_d;
            resp_len_q   <= resp_len_d;
            resp_valid_q <= resp_valid_d;
        end
    end

endmodule

// File: tb/tb_match_extender.sv
// Randomised and directed bench for match_extender against a byte-array history model
// and a reference that derives length, latency and read count from the matching run.
module tb_match_extender;

    localparam int HSIZE = 32768;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [14:0]  req_cur_addr;
    logic [14:0]  req_cand_addr;
    logic [6:0]   req_limit;
    logic         resp_valid;
    logic         resp_ready;
    logic [6:0]   resp_len;
    logic         cur_read_enable;
    logic [14:0]  cur_read_address;
    logic [63:0]  cur_read_data;
    logic         cand_read_enable;
    logic [14:0]  cand_read_address;
    logic [63:0]  cand_read_data;

    logic [7:0]   hist [0:HSIZE-1];
    int           cur_log[$];
    int           cand_log[$];
    int           checks;
    int           errors;

    match_extender dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_cur_addr      (req_cur_addr),
        .req_cand_addr     (req_cand_addr),
        .req_limit         (req_limit),
        .resp_valid        (resp_valid),
        .resp_ready        (resp_ready),
        .resp_len          (resp_len),
        .cur_read_enable   (cur_read_enable),
        .cur_read_address  (cur_read_address),
        .cur_read_data     (cur_read_data),
        .cand_read_enable  (cand_read_enable),
        .cand_read_address (cand_read_address),
        .cand_read_data    (cand_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle-latency unaligned read ports over the shared history, logging every issued address.
    always @(posedge clk) begin
        if (cur_read_enable) begin
            for (int i = 0; i < 8; i++) begin
                cur_read_data[i*8 +: 8] <= hist[(int'(cur_read_address) + i) % HSIZE];
            end
            cur_log.push_back(int'(cur_read_address));
        end
        if (cand_read_enable) begin
            for (int i = 0; i < 8; i++) begin
                cand_read_data[i*8 +: 8] <= hist[(int'(cand_read_address) + i) % HSIZE];
            end
            cand_log.push_back(int'(cand_read_address));
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int run_len(input int cur, input int cand, input int cap);
        int k;
        k = 0;
        while (k < cap && hist[(cur + k) % HSIZE] == hist[(cand + k) % HSIZE]) k++;
        return k;
    endfunction

    task automatic set_match(input int cur, input int cand, input int n);
        for (int k = 0; k < n; k++) hist[(cand + k) % HSIZE] = hist[(cur + k) % HSIZE];
        hist[(cand + n) % HSIZE] = hist[(cur + n) % HSIZE] ^ 8'hA5;
    endtask

    task automatic do_req(input string tag, input int cur, input int cand, input int limit, input int bp);
        int lim, m, elen, j, elat, ereads, lat;
        logic [6:0] held;
        lim  = (limit > 64) ? 64 : limit;
        m    = run_len(cur, cand, 200);
        elen = (m < lim) ? m : lim;
        if (lim == 0) begin
            elat   = 1;
            ereads = 0;
        end else begin
            j      = ((m / 8) < ((lim + 7) / 8 - 1)) ? (m / 8) : ((lim + 7) / 8 - 1);
            elat   = j + 2;
            ereads = j + 2;
        end
        @(negedge clk);
        cur_log.delete();
        cand_log.delete();
        req_valid     = 1'b1;
        req_cur_addr  = cur[14:0];
        req_cand_addr = cand[14:0];
        req_limit     = limit[6:0];
        #1;
        check({tag, "_rdy"}, 32'(req_ready), 32'd1);
        check({tag, "_acc_en"}, 32'(cur_read_enable), 32'(lim != 0));
        if (lim != 0) check({tag, "_acc_addr"}, 32'(cur_read_address), 32'(cur[14:0]));
        @(posedge clk);
        #1;
        req_valid     = 1'b0;
        req_cur_addr  = 15'($urandom);
        req_cand_addr = 15'($urandom);
        req_limit     = 7'($urandom);
        check({tag, "_busy"}, 32'(req_ready), 32'd0);
        @(negedge clk);
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(elat));
        check({tag, "_len"}, 32'(resp_len), 32'(elen));
        held = resp_len;
        for (int b = 0; b < bp; b++) begin
            req_valid     = 1'b1;
            req_cur_addr  = 15'($urandom);
            req_cand_addr = 15'($urandom);
            req_limit     = 7'd64;
            @(negedge clk);
            check({tag, "_bp_valid"}, 32'(resp_valid), 32'd1);
            check({tag, "_bp_len"}, 32'(resp_len), 32'(held));
            check({tag, "_bp_rdy"}, 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        @(negedge clk);
        check({tag, "_post_valid"}, 32'(resp_valid), 32'd0);
        check({tag, "_post_rdy"}, 32'(req_ready), 32'd1);
        check({tag, "_nreads_cur"}, 32'(cur_log.size()), 32'(ereads));
        check({tag, "_nreads_cand"}, 32'(cand_log.size()), 32'(ereads));
        for (int i = 0; i < ereads && i < cur_log.size() && i < cand_log.size(); i++) begin
            check({tag, "_cur_addr"}, 32'(cur_log[i]), 32'((cur + 8 * i) % HSIZE));
            check({tag, "_cand_addr"}, 32'(cand_log[i]), 32'((cand + 8 * i) % HSIZE));
        end
    endtask

    initial begin
        int seen;
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        req_valid     = 1'b0;
        req_cur_addr  = '0;
        req_cand_addr = '0;
        req_limit     = '0;
        resp_ready    = 1'b0;
        for (int i = 0; i < HSIZE; i++) hist[i] = 8'($urandom);
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_len", 32'(resp_len), 32'd0);
        check("rst_cur_en", 32'(cur_read_enable), 32'd0);
        check("rst_cand_en", 32'(cand_read_enable), 32'd0);
        check("rst_rdy", 32'(req_ready), 32'd1);
        rst_n = 1'b1;

        set_match(32'h0100, 32'h0040, 5);
        do_req("m5", 32'h0100, 32'h0040, 64, 0);
        set_match(32'h0100, 32'h0040, 20);
        do_req("m20", 32'h0100, 32'h0040, 64, 0);
        set_match(32'h0100, 32'h0040, 200);
        do_req("clamp", 32'h0100, 32'h0040, 100, 0);
        do_req("lim13", 32'h0100, 32'h0040, 13, 0);
        do_req("lim0", 32'h0100, 32'h0040, 0, 0);
        do_req("lim16", 32'h0100, 32'h0040, 16, 0);
        set_match(32'h7FFC, 32'h1000, 12);
        do_req("wrap", 32'h7FFC, 32'h1000, 64, 0);
        set_match(32'h2000, 32'h3000, 9);
        do_req("bp", 32'h2000, 32'h3000, 64, 3);

        for (int t = 0; t < 40; t++) begin
            int c, d, lm, n;
            c  = int'($urandom_range(0, HSIZE - 1));
            d  = int'($urandom_range(0, HSIZE - 1));
            lm = int'($urandom_range(0, 100));
            n  = int'($urandom_range(0, 70));
            set_match(c, d, n);
            do_req("rnd", c, d, lm, int'($urandom_range(0, 2)));
        end

        set_match(32'h0200, 32'h0300, 200);
        @(negedge clk);
        req_valid     = 1'b1;
        req_cur_addr  = 15'h0200;
        req_cand_addr = 15'h0300;
        req_limit     = 7'd64;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(resp_valid), 32'd0);
        check("arst_len", 32'(resp_len), 32'd0);
        check("arst_cur_en", 32'(cur_read_enable), 32'd0);
        check("arst_cand_en", 32'(cand_read_enable), 32'd0);
        check("arst_rdy", 32'(req_ready), 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        seen  = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) seen++;
        end
        check("arst_no_stale", 32'(seen), 32'd0);
        check("arst_rdy_after", 32'(req_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
